// File: rtl/prescaled_counter_if.sv
// ---------------------------------------------------------------------------
// prescaled_counter_if
//   Bundles the control inputs and the statistics outputs of
//   prescaled_counter so that a driver (master) and the counter (slave)
//   share one connection.
//
//   Signals:
//     en        count enable
//     sel       mode select: 0 = fast counter, 1 = slow/prescaled counter
//     clr       synchronous clear of counters, prescaler and flags
//     load      synchronous load of the selected counter
//     load_val  value loaded by load (WIDTH bits)
//     output0   fast counter value
//     output1   slow counter value
//     ovf0      sticky overflow of the fast counter
//     ovf1      sticky overflow of the slow counter
//     tick      one-cycle pulse for every slow counter increment event
//
//   Modports:
//     master  drives the controls, observes the counters
//     slave   the counter itself
// ---------------------------------------------------------------------------
interface prescaled_counter_if #(
  parameter int WIDTH = 64
);

  logic             en;
  logic             sel;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] output0;
  logic [WIDTH-1:0] output1;
  logic             ovf0;
  logic             ovf1;
  logic             tick;

  modport master (
    output en,
    output sel,
    output clr,
    output load,
    output load_val,
    input  output0,
    input  output1,
    input  ovf0,
    input  ovf1,
    input  tick
  );

  modport slave (
    input  en,
    input  sel,
    input  clr,
    input  load,
    input  load_val,
    output output0,
    output output1,
    output ovf0,
    output ovf1,
    output tick
  );

endinterface : prescaled_counter_if

// File: rtl/prescaled_counter.sv
// ---------------------------------------------------------------------------
// prescaled_counter
//   Dual statistics counter.
//     - Fast counter (output0) counts enabled cycles while sel = 0.
//     - Slow counter (output1) counts every DIV-th enabled cycle while
//       sel = 1, using an internal prescaler that keeps its phase across
//       sel = 0 periods.
//   Edge priority is clr > load > en. Every output is a register.
//
//   Parameters:
//     WIDTH     counter / load_val width (>= 2)
//     DIV       prescaler divisor for the slow counter (>= 1)
//     SATURATE  0 = counters wrap to zero past all-ones,
//               1 = counters hold at all-ones
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    prescaled_counter_if.slave (controls in, counters/flags out)
// ---------------------------------------------------------------------------
module prescaled_counter #(
  parameter int WIDTH    = 64,
  parameter int DIV      = 3,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  prescaled_counter_if.slave    bus
);

  // A single-state prescaler (DIV = 1) still needs one bit to exist.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // Registered state.
  logic [WIDTH-1:0] out0_r;
  logic [WIDTH-1:0] out1_r;
  logic [PW-1:0]    pre_r;
  logic             ovf0_r;
  logic             ovf1_r;
  logic             tick_r;

  // Next-state values.
  logic [WIDTH-1:0] out0_nxt_s;
  logic [WIDTH-1:0] out1_nxt_s;
  logic [PW-1:0]    pre_nxt_s;
  logic             ovf0_nxt_s;
  logic             ovf1_nxt_s;
  logic             tick_nxt_s;

  // Incrementer results: MSB is the "was all-ones" overflow indication.
  logic [WIDTH:0]   inc0_s;
  logic [WIDTH:0]   inc1_s;
  logic             pre_wrap_s;

  // Increment with overflow detection. At all-ones the result either wraps
  // to zero or stays pinned, depending on SATURATE; overflow is reported in
  // both cases so the sticky flag sets regardless of the mode.
  function automatic logic [WIDTH:0] incr(input logic [WIDTH-1:0] value);
    logic [WIDTH:0] result;
    if (value == {WIDTH{1'b1}}) begin
      if (SATURATE != 0) begin
        result = {1'b1, value};
      end else begin
        result = {1'b1, {WIDTH{1'b0}}};
      end
    end else begin
      result = {1'b0, value + WIDTH'(1)};
    end
    return result;
  endfunction

  // Incrementer outputs and prescaler terminal-count detection.
  always_comb begin
    inc0_s     = incr(out0_r);
    inc1_s     = incr(out1_r);
    pre_wrap_s = (pre_r == PRE_LAST);
  end

  // Next-state selection following clr > load > en priority.
  always_comb begin
    out0_nxt_s = out0_r;
    out1_nxt_s = out1_r;
    pre_nxt_s  = pre_r;
    ovf0_nxt_s = ovf0_r;
    ovf1_nxt_s = ovf1_r;
    tick_nxt_s = 1'b0;

    if (bus.clr) begin
      out0_nxt_s = {WIDTH{1'b0}};
      out1_nxt_s = {WIDTH{1'b0}};
      pre_nxt_s  = {PW{1'b0}};
      ovf0_nxt_s = 1'b0;
      ovf1_nxt_s = 1'b0;
    end else if (bus.load) begin
      // Loading the slow counter restarts its prescaler phase so the next
      // slow increment is a full DIV enabled cycles away.
      if (bus.sel) begin
        out1_nxt_s = bus.load_val;
        pre_nxt_s  = {PW{1'b0}};
      end else begin
        out0_nxt_s = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.sel) begin
        // Slow mode zeroes the fast counter every enabled cycle.
        out0_nxt_s = {WIDTH{1'b0}};
        if (pre_wrap_s) begin
          pre_nxt_s  = {PW{1'b0}};
          out1_nxt_s = inc1_s[WIDTH-1:0];
          ovf1_nxt_s = ovf1_r | inc1_s[WIDTH];
          // tick marks the increment event even when a saturated counter
          // does not visibly change.
          tick_nxt_s = 1'b1;
        end else begin
          pre_nxt_s  = pre_r + PW'(1);
        end
      end else begin
        out0_nxt_s = inc0_s[WIDTH-1:0];
        ovf0_nxt_s = ovf0_r | inc0_s[WIDTH];
      end
    end else begin
      // Idle: everything holds, tick stays low.
      tick_nxt_s = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out0_r <= {WIDTH{1'b0}};
      out1_r <= {WIDTH{1'b0}};
      pre_r  <= {PW{1'b0}};
      ovf0_r <= 1'b0;
      ovf1_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      out0_r <= out0_nxt_s;
      out1_r <= out1_nxt_s;
      pre_r  <= pre_nxt_s;
      ovf0_r <= ovf0_nxt_s;
      ovf1_r <= ovf1_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  // Drive the interface straight from the registers.
  assign bus.output0 = out0_r;
  assign bus.output1 = out1_r;
  assign bus.ovf0    = ovf0_r;
  assign bus.ovf1    = ovf1_r;
  assign bus.tick    = tick_r;

endmodule : prescaled_counter

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
- Parametrised dual counter for event and cycle statistics.
- Fast counter counts enabled cycles while sel=0.
- Slow counter counts every DIV-th enabled cycle while sel=1, via an internal prescaler.
- Adds width/divisor/overflow-mode parameters, synchronous clear and load, sticky overflow flags and a prescaler tick.

Parameters:
- WIDTH, 64, bit width of both counters and load_val (>=2).
- DIV, 3, prescaler divisor for the slow counter (>=1).
- SATURATE, 0, 0 = counters wrap to 0 at max; 1 = counters hold at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- en  input  1  count enable.
- sel  input  1  mode: 0 = fast, 1 = slow/prescaled.
- clr  input  1  synchronous clear of counters, prescaler and flags.
- load  input  1  synchronous load of the selected counter.
- load_val  input  WIDTH  value for load.
- output0  output  WIDTH  fast counter value.
- output1  output  WIDTH  slow counter value.
- ovf0  output  1  sticky overflow, fast counter.
- ovf1  output  1  sticky overflow, slow counter.
- tick  output  1  one-cycle pulse when output1 increments.

Behaviour:
- Reset (async, any time):
  - output0=0, output1=0, ovf0=0, ovf1=0, tick=0, prescaler=0.
  - Takes effect immediately, mid-count included.
- Per-edge priority: clr > load > en. All outputs registered.
- clr=1:
  - Counters, prescaler, ovf0 and ovf1 go to 0; tick=0.
  - load and en are ignored that cycle.
- load=1, clr=0:
  - sel=0: output0<=load_val, prescaler unchanged.
  - sel=1: output1<=load_val, prescaler<=0.
  - The other counter holds; no counting that cycle; tick=0; flags unchanged.
- en=1, sel=0, no clr/load:
  - output0 increments by 1. output1 and prescaler hold.
- en=1, sel=1, no clr/load:
  - output0<=0.
  - Prescaler counts 0..DIV-1.
  - If prescaler==DIV-1: prescaler<=0, output1 increments, tick=1 next cycle.
  - Otherwise prescaler+1, tick=0.
  - First slow increment occurs on the DIV-th consecutive sel=1 enabled cycle, then every DIV thereafter.
  - DIV=1: output1 increments on every enabled cycle; prescaler is constant 0.
- en=0: all counters and prescaler hold; tick=0.
- Prescaler retains its value across sel changes; sel=0 periods neither advance nor clear it.
- Increment at all-ones:
  - SATURATE=0: counter wraps to 0.
  - SATURATE=1: counter holds all-ones.
  - In both modes the matching ovf flag sets to 1 and stays set until clr or reset.
  - With SATURATE=1, tick still pulses on the prescaler wrap even when output1 holds.
- tick is high exactly one cycle per output1 increment event, aligned with the edge that updates output1.
- Arithmetic: unsigned, modulo 2^WIDTH. Prescaler width is max(1, clog2(DIV)).

Test Plan:
- Reset then 5 cycles en=1,sel=0 -> output0=5, output1=0, tick never high. Assert reset mid-run -> output0=0 immediately, without waiting for a clock edge.
- DIV=3: output0=7, then 9 cycles en=1,sel=1 -> output0=0 after the first edge; output1=3; tick high on cycles 3, 6 and 9 only.
- DIV=3, sel=1: 2 enabled cycles, sel=0 for 4 cycles (output0=4), sel=1 for 1 cycle -> output1=1; prescaler value was retained across the sel=0 period.
- WIDTH=8, SATURATE=0: load 8'hFE with sel=0, then 3 enabled cycles -> output0 sequence FF, 00, 01; ovf0=1 from the wrap cycle onward. Repeat with SATURATE=1 -> FF, FF, FF, ovf0=1.
- Simultaneous clr=1, load=1, en=1 -> all outputs 0, flags 0. Simultaneous load=1 (load_val=10), en=1, sel=1 -> output1=10, prescaler 0, tick 0.
- DIV=1, sel=1, en toggling 1,0,1,1 -> output1=3; tick high on each enabled edge only.
